// File: rtl/flow_pkg.sv
// Constants and FSM state type shared by the optical-flow pyramid blocks.
package flow_pkg;

    localparam int FLOW_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_READ,
        ST_SCALE,
        ST_WRITE
    } flow_state_e;

endpackage

// File: rtl/flow_sat_double.sv
// Combinational x2 of a signed flow component.
// FLOW_UPSAMPLE_SAT_EN selects clamping on overflow; otherwise the result wraps.
module flow_sat_double
    import flow_pkg::*;
#(
    parameter int FLOW_WIDTH = FLOW_WIDTH_DEF
) (
    input  logic signed [FLOW_WIDTH-1:0] in_i,
    output logic signed [FLOW_WIDTH-1:0] out_o
);

`ifdef FLOW_UPSAMPLE_SAT_EN
    localparam logic signed [FLOW_WIDTH-1:0] MAX_VAL = {1'b0, {(FLOW_WIDTH-1){1'b1}}};
    localparam logic signed [FLOW_WIDTH-1:0] MIN_VAL = {1'b1, {(FLOW_WIDTH-1){1'b0}}};

    // Overflow happens exactly when the two top bits disagree.
    always_comb begin
        if (in_i[FLOW_WIDTH-1] == in_i[FLOW_WIDTH-2]) begin
            out_o = {in_i[FLOW_WIDTH-2:0], 1'b0};
        end else if (in_i[FLOW_WIDTH-1]) begin
            out_o = MIN_VAL;
        end else begin
            out_o = MAX_VAL;
        end
    end
`else
    assign out_o = {in_i[FLOW_WIDTH-2:0], 1'b0};
`endif

endmodule

// File: rtl/flow_upsampler.sv
// Upsamples one coarse flow level into 2x2 fine blocks of doubled vectors.
// Build with FLOW_UPSAMPLE_SAT_EN to saturate the doubling instead of wrapping.
module flow_upsampler
    import flow_pkg::*;
#(
    parameter int FLOW_WIDTH = FLOW_WIDTH_DEF,
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] coarse_flow_addr,
    output logic                  coarse_flow_re,
    input  logic [FLOW_WIDTH-1:0] coarse_flow_u_data,
    input  logic [FLOW_WIDTH-1:0] coarse_flow_v_data,
    output logic [ADDR_WIDTH-1:0] base_flow_addr,
    output logic [FLOW_WIDTH-1:0] base_flow_u_data,
    output logic [FLOW_WIDTH-1:0] base_flow_v_data,
    output logic                  base_flow_we
);

    localparam logic [ADDR_WIDTH-1:0] CX_LAST  = ADDR_WIDTH'(WIDTH / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] CY_LAST  = ADDR_WIDTH'(HEIGHT / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(2 * WIDTH);
    localparam logic [ADDR_WIDTH-1:0] DY_STEP  = ADDR_WIDTH'(WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    flow_state_e           state_q;
    logic [ADDR_WIDTH-1:0] cx_q;
    logic [ADDR_WIDTH-1:0] cy_q;
    logic [ADDR_WIDTH-1:0] row_base_q;
    logic [1:0]            sub_q;
    logic [FLOW_WIDTH-1:0] u_raw_q;
    logic [FLOW_WIDTH-1:0] v_raw_q;
    logic [ADDR_WIDTH-1:0] coarse_addr_q;
    logic                  re_q;
    logic [ADDR_WIDTH-1:0] base_addr_q;
    logic [FLOW_WIDTH-1:0] base_u_q;
    logic [FLOW_WIDTH-1:0] base_v_q;
    logic                  we_q;
    logic                  done_q;
    logic [FLOW_WIDTH-1:0] dbl_u_d;
    logic [FLOW_WIDTH-1:0] dbl_v_d;
    logic                  last_pixel_d;

    flow_sat_double #(.FLOW_WIDTH(FLOW_WIDTH)) u_dbl_u (.in_i(u_raw_q), .out_o(dbl_u_d));
    flow_sat_double #(.FLOW_WIDTH(FLOW_WIDTH)) u_dbl_v (.in_i(v_raw_q), .out_o(dbl_v_d));

    assign last_pixel_d = (cx_q == CX_LAST) && (cy_q == CY_LAST);

    // row_base_q tracks 2*cy*WIDTH so fine addresses need only adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cx_q          <= '0;
            cy_q          <= '0;
            row_base_q    <= '0;
            sub_q         <= '0;
            u_raw_q       <= '0;
            v_raw_q       <= '0;
            coarse_addr_q <= '0;
            re_q          <= 1'b0;
            base_addr_q   <= '0;
            base_u_q      <= '0;
            base_v_q      <= '0;
            we_q          <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            re_q   <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q       <= ST_READ;
                        re_q          <= 1'b1;
                        coarse_addr_q <= '0;
                    end
                end
                ST_READ: begin
                    state_q <= ST_WAIT_READ;
                end
                ST_WAIT_READ: begin
                    u_raw_q <= coarse_flow_u_data;
                    v_raw_q <= coarse_flow_v_data;
                    state_q <= ST_SCALE;
                end
                ST_SCALE: begin
                    state_q     <= ST_WRITE;
                    sub_q       <= 2'd0;
                    we_q        <= 1'b1;
                    base_addr_q <= row_base_q + {cx_q[ADDR_WIDTH-2:0], 1'b0};
                    base_u_q    <= dbl_u_d;
                    base_v_q    <= dbl_v_d;
                end
                ST_WRITE: begin
                    sub_q <= sub_q + 2'd1;
                    if (sub_q != 2'd3) begin
                        // After (0,1) step down a fine row and back one column.
                        we_q        <= 1'b1;
                        base_addr_q <= base_addr_q + ((sub_q == 2'd1) ? DY_STEP : ONE);
                        done_q      <= last_pixel_d && (sub_q == 2'd2);
                    end else if (last_pixel_d) begin
                        state_q    <= ST_IDLE;
                        cx_q       <= '0;
                        cy_q       <= '0;
                        row_base_q <= '0;
                    end else begin
                        state_q       <= ST_READ;
                        re_q          <= 1'b1;
                        coarse_addr_q <= coarse_addr_q + ONE;
                        if (cx_q == CX_LAST) begin
                            cx_q       <= '0;
                            cy_q       <= cy_q + ONE;
                            row_base_q <= row_base_q + ROW_STEP;
                        end else begin
                            cx_q <= cx_q + ONE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign coarse_flow_addr = coarse_addr_q;
    assign coarse_flow_re   = re_q;
    assign base_flow_addr   = base_addr_q;
    assign base_flow_u_data = base_u_q;
    assign base_flow_v_data = base_v_q;
    assign base_flow_we     = we_q;

endmodule

// File: tb/tb_flow_upsampler.sv
// Bench for flow_upsampler: 4x4 instance against a block-level model, plus a
// full-size 160x120 instance for pass length. Honors FLOW_UPSAMPLE_SAT_EN.
module tb_flow_upsampler;

    localparam int FW = 16;
    localparam int AW = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_big = 1'b0;

    logic          busy, done, coarse_re, base_we;
    logic [AW-1:0] coarse_addr, base_addr;
    logic [FW-1:0] coarse_u, coarse_v, base_u, base_v;

    logic          busy_big, done_big, re_big, we_big;
    logic [AW-1:0] caddr_big, baddr_big;
    logic [FW-1:0] bu_big, bv_big;
    logic [FW-1:0] cu_big = '0;
    logic [FW-1:0] cv_big = '0;

    logic [FW-1:0] mem_u [4];
    logic [FW-1:0] mem_v [4];

    logic [AW+2*FW-1:0] exp_q[$];
    logic [AW-1:0] log_addr [64];
    logic [FW-1:0] log_u [64];
    logic [FW-1:0] log_v [64];
    int wr_cnt;
    int done_cnt;
    int errors;
    int checks;

    typedef struct {
        logic [FW-1:0] u;
        logic [FW-1:0] v;
        logic [FW-1:0] eu_wrap;
        logic [FW-1:0] ev_wrap;
        logic [FW-1:0] eu_sat;
        logic [FW-1:0] ev_sat;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    flow_upsampler #(.FLOW_WIDTH(FW), .WIDTH(4), .HEIGHT(4), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .coarse_flow_addr(coarse_addr), .coarse_flow_re(coarse_re),
        .coarse_flow_u_data(coarse_u), .coarse_flow_v_data(coarse_v),
        .base_flow_addr(base_addr), .base_flow_u_data(base_u),
        .base_flow_v_data(base_v), .base_flow_we(base_we)
    );

    flow_upsampler #(.FLOW_WIDTH(FW), .WIDTH(160), .HEIGHT(120), .ADDR_WIDTH(AW)) dut_big (
        .clk(clk), .rst(rst), .start(start_big), .busy(busy_big), .done(done_big),
        .coarse_flow_addr(caddr_big), .coarse_flow_re(re_big),
        .coarse_flow_u_data(cu_big), .coarse_flow_v_data(cv_big),
        .base_flow_addr(baddr_big), .base_flow_u_data(bu_big),
        .base_flow_v_data(bv_big), .base_flow_we(we_big)
    );

    // Coarse memory: one-cycle read latency.
    always @(posedge clk) begin
        if (coarse_re) begin
            coarse_u <= mem_u[coarse_addr[1:0]];
            coarse_v <= mem_v[coarse_addr[1:0]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] model_dbl(input logic [FW-1:0] x);
        int d;
        d = 2 * int'($signed(x));
`ifdef FLOW_UPSAMPLE_SAT_EN
        if (d > 32767) d = 32767;
        else if (d < -32768) d = -32768;
`endif
        return d[FW-1:0];
    endfunction

    // Every fine pixel of coarse block (cx,cy) carries that block's doubled vector.
    task automatic fill_expected();
        for (int cy = 0; cy < 2; cy++)
            for (int cx = 0; cx < 2; cx++)
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++)
                        exp_q.push_back({AW'((2 * cy + dy) * 4 + 2 * cx + dx),
                                         model_dbl(mem_u[cy * 2 + cx]),
                                         model_dbl(mem_v[cy * 2 + cx])});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) done_cnt++;
        if (base_we) begin
            if (wr_cnt < 64) begin
                log_addr[wr_cnt] = base_addr;
                log_u[wr_cnt] = base_u;
                log_v[wr_cnt] = base_v;
            end
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {15'd0, base_addr, base_u, base_v}, 64'd0);
            end else begin
                check("write", {15'd0, base_addr, base_u, base_v}, {15'd0, exp_q.pop_front()});
            end
        end
    endtask

    // Pulses start, returns the cycle at which done is seen, then steps one more cycle.
    task automatic run_pass(output int cycles);
        wr_cnt = 0;
        done_cnt = 0;
        fill_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 200) begin
            tick();
            cycles++;
        end
        if (!done) check("pass_timeout", 64'(cycles), 64'd28);
        tick();
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 4; i++) begin
            mem_u[i] = FW'(i);
            mem_v[i] = FW'(-i);
        end
    endtask

    int cyc;
    int k;
    logic [FW-1:0] eu, ev;

    initial begin
        errors = 0;
        checks = 0;
        wr_cnt = 0;
        done_cnt = 0;
        vecs[0] = '{16'd20000, -16'sd20000, -16'sd25536, 16'd25536, 16'd32767, -16'sd32768};
        vecs[1] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[2] = '{16'd1, -16'sd1, 16'd2, -16'sd2, 16'd2, -16'sd2};
        vecs[3] = '{16'd16383, -16'sd16384, 16'd32766, -16'sd32768, 16'd32766, -16'sd32768};
        vecs[4] = '{16'd16384, -16'sd16385, -16'sd32768, 16'd32766, 16'd32767, -16'sd32768};
        vecs[5] = '{16'd32767, -16'sd32768, -16'sd2, 16'd0, 16'd32767, -16'sd32768};
        vecs[6] = '{-16'sd1, 16'd12345, -16'sd2, 16'd24690, -16'sd2, 16'd24690};
        vecs[7] = '{-16'sd8000, 16'd100, -16'sd16000, 16'd200, -16'sd16000, 16'd200};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_re", 64'(coarse_re), 64'd0);
        check("rst_we", 64'(base_we), 64'd0);
        check("rst_coarse_addr", 64'(coarse_addr), 64'd0);
        check("rst_base_addr", 64'(base_addr), 64'd0);
        check("rst_base_data", {32'd0, base_u, base_v}, 64'd0);
        rst = 1'b0;
        tick();

        // Ramp: u=i, v=-i, 28-cycle pass and block-1/2 address order
        load_ramp();
        run_pass(cyc);
        check("ramp_cycles", 64'(cyc), 64'd28);
        check("ramp_writes", 64'(wr_cnt), 64'd16);
        check("ramp_done_cnt", 64'(done_cnt), 64'd1);
        check("ramp_blk1_addr", {16'd0, log_addr[4][11:0], log_addr[5][11:0], log_addr[6][11:0], log_addr[7][11:0]},
              {16'd0, 12'd2, 12'd3, 12'd6, 12'd7});
        check("ramp_blk2_addr", {16'd0, log_addr[8][11:0], log_addr[9][11:0], log_addr[10][11:0], log_addr[11][11:0]},
              {16'd0, 12'd8, 12'd9, 12'd12, 12'd13});
        check("idle_after_pass", 64'(busy), 64'd0);

        // Doubling table, four vectors per pass
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                mem_u[i] = vecs[p * 4 + i].u;
                mem_v[i] = vecs[p * 4 + i].v;
            end
            run_pass(cyc);
            for (int i = 0; i < 4; i++) begin
`ifdef FLOW_UPSAMPLE_SAT_EN
                eu = vecs[p * 4 + i].eu_sat;
                ev = vecs[p * 4 + i].ev_sat;
`else
                eu = vecs[p * 4 + i].eu_wrap;
                ev = vecs[p * 4 + i].ev_wrap;
`endif
                for (int j = 0; j < 4; j++)
                    check("table_vec", {32'd0, log_u[4 * i + j], log_v[4 * i + j]}, {32'd0, eu, ev});
            end
        end

        // Random passes, back-to-back (start in the cycle after done)
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                mem_u[i] = FW'($urandom_range(0, 65535));
                mem_v[i] = FW'($urandom_range(0, 65535));
            end
            run_pass(cyc);
            check("rand_cycles", 64'(cyc), 64'd28);
            check("rand_writes", 64'(wr_cnt), 64'd16);
        end

        // start repeated mid-pass is ignored
        load_ramp();
        wr_cnt = 0;
        done_cnt = 0;
        fill_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (k = 1; k < 60; k++) begin
            start = (k == 4);
            tick();
        end
        start = 1'b0;
        check("restart_done_cnt", 64'(done_cnt), 64'd1);
        check("restart_writes", 64'(wr_cnt), 64'd16);
        check("restart_exp_left", 64'(exp_q.size()), 64'd0);

        // Reset at cycle 10 aborts, next pass restarts from pixel 0
        wr_cnt = 0;
        fill_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (k = 1; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_we", 64'(base_we), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_writes", 64'(wr_cnt), 64'd4);
        exp_q.delete();
        for (k = 0; k < 5; k++) tick();
        check("abort_silent", 64'(wr_cnt), 64'd4);
        load_ramp();
        run_pass(cyc);
        check("after_abort_cycles", 64'(cyc), 64'd28);
        check("after_abort_writes", 64'(wr_cnt), 64'd16);
        check("after_abort_first_addr", 64'(log_addr[0]), 64'd0);
        check("final_exp_left", 64'(exp_q.size()), 64'd0);

        // Full-size level
        start_big = 1'b1;
        tick();
        start_big = 1'b0;
        cyc = 1;
        while (!done_big && cyc < 34000) begin
            tick();
            cyc++;
        end
        check("big_done_cycle", 64'(cyc), 64'd33600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
